// File: rtl/fir_out_condition.sv
// rtl/fir_out_condition.sv - FIR output conditioner: decimate, round, narrow, FWFT buffer
//
// Takes wide FIR accumulator samples, keeps one in every DECIM valid samples,
// rounds half-up by 2^SHIFT, narrows to OUT_WIDTH and queues the result in a
// small first-word-fall-through FIFO.
//
// Optional feature macro: FIR_OUT_SAT_EN
//   defined   : narrowing clamps to the OUT_WIDTH signed range, sat_flag records clamps
//   undefined : narrowing keeps the low OUT_WIDTH bits (wrap), sat_flag is constant 0
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data, in_valid      upstream sample stream (no backpressure)
//   out_data, out_valid    FIFO head and non-empty indication
//   out_ready              consumer accept; transfer when out_valid && out_ready
//   fifo_level             current FIFO occupancy
//   drop_flag, sat_flag    sticky status flags
//   flag_clr               synchronous clear of both flags, wins over a same-cycle set

module fir_out_condition #(
   parameter int IN_WIDTH   = 33,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 17,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [IN_WIDTH-1:0]    in_data,
   input  logic                          in_valid,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          drop_flag,
   output logic                          sat_flag,
   input  logic                          flag_clr
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
   localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);

   logic [PW-1:0]                 phase_q, phase_d;
   logic signed [OUT_WIDTH-1:0]   stage_q, stage_d;
   logic                          stage_valid_q, stage_valid_d;
   logic signed [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic signed [OUT_WIDTH-1:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [AW:0]                   fifo_level_q, fifo_level_d;
   logic                          drop_flag_q, drop_flag_d;

   logic                          keep;
   logic signed [IN_WIDTH:0]      rnd_sum;
   logic signed [IN_WIDTH:0]      rnd;
   logic signed [OUT_WIDTH-1:0]   narrow;
   logic                          full;
   logic                          pop;
   logic                          wr_en;
   logic                          drop;

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [IN_WIDTH:0] SAT_MAX =
      {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] SAT_MIN =
      {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
   logic sat_flag_q, sat_flag_d;
   logic clip;
`endif

   always_comb begin
      // Decimation: only the phase-0 sample of each group of DECIM is kept
      keep    = in_valid && (phase_q == '0);
      phase_d = phase_q;
      if (in_valid) begin
         phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      end

      // One extra bit of headroom so adding the half-LSB cannot overflow
      rnd_sum = (IN_WIDTH + 1)'(in_data) + HALF;
      rnd     = rnd_sum >>> SHIFT;

`ifdef FIR_OUT_SAT_EN
      clip = 1'b1;
      if (rnd > SAT_MAX) begin
         narrow = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      end else if (rnd < SAT_MIN) begin
         narrow = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      end else begin
         narrow = OUT_WIDTH'(rnd);
         clip   = 1'b0;
      end
`else
      narrow = OUT_WIDTH'(rnd);
`endif

      stage_d       = keep ? narrow : stage_q;
      stage_valid_d = keep;

      // FIFO: a pop frees the slot in the same cycle, so push+pop works even when full
      full  = (fifo_level_q == LEVEL_FULL);
      pop   = out_valid && out_ready;
      wr_en = stage_valid_q && (!full || pop);
      drop  = stage_valid_q && full && !pop;

      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = stage_q;
      end
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);

      fifo_level_d = fifo_level_q;
      case ({wr_en, pop})
         2'b10:   fifo_level_d = fifo_level_q + (AW + 1)'(1);
         2'b01:   fifo_level_d = fifo_level_q - (AW + 1)'(1);
         default: fifo_level_d = fifo_level_q;
      endcase

      drop_flag_d = flag_clr ? 1'b0 : (drop_flag_q | drop);
`ifdef FIR_OUT_SAT_EN
      sat_flag_d  = flag_clr ? 1'b0 : (sat_flag_q | (keep & clip));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q       <= '0;
         stage_q       <= '0;
         stage_valid_q <= 1'b0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_level_q  <= '0;
         drop_flag_q   <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         stage_q       <= stage_d;
         stage_valid_q <= stage_valid_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_level_q  <= fifo_level_d;
         drop_flag_q   <= drop_flag_d;
      end
   end

`ifdef FIR_OUT_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag_q <= 1'b0;
      end else begin
         sat_flag_q <= sat_flag_d;
      end
   end
   assign sat_flag = sat_flag_q;
`else
   assign sat_flag = 1'b0;
`endif

   assign out_valid  = (fifo_level_q != '0);
   // Held at zero while empty so the output is defined after reset
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = fifo_level_q;
   assign drop_flag  = drop_flag_q;

endmodule

// File: tb/tb_fir_out_condition.sv
// tb/tb_fir_out_condition.sv - scoreboard bench for fir_out_condition (DECIM=1 and DECIM=4 instances)

module tb_fir_out_condition;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic signed [32:0] in_data_1, in_data_4;
   logic               in_valid_1, in_valid_4;
   logic signed [15:0] out_data_1, out_data_4;
   logic               out_valid_1, out_valid_4;
   logic               out_ready_1, out_ready_4;
   logic [2:0]         fifo_level_1, fifo_level_4;
   logic               drop_flag_1, drop_flag_4;
   logic               sat_flag_1, sat_flag_4;
   logic               flag_clr_1, flag_clr_4;

   int checks   = 0;
   int failures = 0;

   logic signed [15:0] q1[$];
   logic signed [15:0] q4[$];

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [15:0] EXP_POS_OVF = 16'sd32767;
   localparam logic               EXP_SAT     = 1'b1;
`else
   localparam logic signed [15:0] EXP_POS_OVF = -16'sd32768;
   localparam logic               EXP_SAT     = 1'b0;
`endif

   fir_out_condition #(.IN_WIDTH(33), .OUT_WIDTH(16), .SHIFT(17), .DECIM(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_1), .in_valid(in_valid_1),
      .out_data(out_data_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
      .fifo_level(fifo_level_1), .drop_flag(drop_flag_1), .sat_flag(sat_flag_1),
      .flag_clr(flag_clr_1));

   fir_out_condition #(.IN_WIDTH(33), .OUT_WIDTH(16), .SHIFT(17), .DECIM(4), .FIFO_DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_4), .in_valid(in_valid_4),
      .out_data(out_data_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
      .fifo_level(fifo_level_4), .drop_flag(drop_flag_4), .sat_flag(sat_flag_4),
      .flag_clr(flag_clr_4));

   // Scoreboard: every accepted output is popped against the expected queue
   always @(negedge clk) begin
      logic signed [15:0] e;
      if (rst_n && out_valid_1 && out_ready_1) begin
         checks++;
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL sb_u1_unexpected got=%0d expected=none", out_data_1);
         end else begin
            e = q1.pop_front();
            if (out_data_1 !== e) begin
               failures++;
               $display("FAIL sb_u1_data got=%0d expected=%0d", out_data_1, e);
            end
         end
      end
      if (rst_n && out_valid_4 && out_ready_4) begin
         checks++;
         if (q4.size() == 0) begin
            failures++;
            $display("FAIL sb_u4_unexpected got=%0d expected=none", out_data_4);
         end else begin
            e = q4.pop_front();
            if (out_data_4 !== e) begin
               failures++;
               $display("FAIL sb_u4_data got=%0d expected=%0d", out_data_4, e);
            end
         end
      end
   end

   task automatic wait_drain(input int which, output bit ok);
      for (int i = 0; i < 60; i++) begin
         if (((which == 1) ? q1.size() : q4.size()) == 0) break;
         @(negedge clk);
      end
      ok = (((which == 1) ? q1.size() : q4.size()) == 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid_1, out_data_1, fifo_level_1, drop_flag_1, sat_flag_1} !== 22'd0) begin
         failures++;
         $display("FAIL reset_u1 got=%h expected=0",
                  {out_valid_1, out_data_1, fifo_level_1, drop_flag_1, sat_flag_1});
      end
      checks++;
      if ({out_valid_4, out_data_4, fifo_level_4, drop_flag_4, sat_flag_4} !== 22'd0) begin
         failures++;
         $display("FAIL reset_u4 got=%h expected=0",
                  {out_valid_4, out_data_4, fifo_level_4, drop_flag_4, sat_flag_4});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_rounding;
      longint vals[5] = '{65536, 65535, -65536, -65537, 655360};
      longint exps[5] = '{1, 0, 0, -1, 5};
      out_ready_1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_data_1  = 33'(vals[i]);
         in_valid_1 = 1'b1;
         q1.push_back(16'(exps[i]));
         @(posedge clk);
         #1 in_valid_1 = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid_1 !== 1'b0) begin
            failures++;
            $display("FAIL round_early_%0d got=%b expected=0", i, out_valid_1);
         end
         @(negedge clk);
         checks++;
         if (out_valid_1 !== 1'b1 || out_data_1 !== 16'(exps[i])) begin
            failures++;
            $display("FAIL round_lat2_%0d got=%b/%0d expected=1/%0d", i, out_valid_1, out_data_1, exps[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation;
      bit ok;
      out_ready_1 = 1'b1;
      in_data_1  = 33'(64'sd4294967295);
      in_valid_1 = 1'b1;
      q1.push_back(EXP_POS_OVF);
      @(posedge clk);
      #1 in_valid_1 = 1'b0;
      wait_drain(1, ok);
      checks++;
      if (!ok || sat_flag_1 !== EXP_SAT) begin
         failures++;
         $display("FAIL sat_pos drained=%0d sat_flag=%b expected=%b", ok, sat_flag_1, EXP_SAT);
      end
      in_data_1  = 33'(-64'sd4294967296);
      in_valid_1 = 1'b1;
      q1.push_back(-16'sd32768);
      @(posedge clk);
      #1 in_valid_1 = 1'b0;
      wait_drain(1, ok);
      checks++;
      if (!ok || sat_flag_1 !== EXP_SAT) begin
         failures++;
         $display("FAIL sat_neg_sticky drained=%0d sat_flag=%b expected=%b", ok, sat_flag_1, EXP_SAT);
      end
      flag_clr_1 = 1'b1;
      @(posedge clk);
      #1 flag_clr_1 = 1'b0;
      checks++;
      if (sat_flag_1 !== 1'b0) begin
         failures++;
         $display("FAIL sat_clear got=%b expected=0", sat_flag_1);
      end
   endtask

   task automatic test_decimation;
      bit ok;
      out_ready_4 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_data_4  = 33'(k * 131072);
         in_valid_4 = 1'b1;
         if (k == 1 || k == 5) q4.push_back(16'(k));
         @(posedge clk);
         #1;
      end
      in_valid_4 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         in_data_4  = 33'(k * 131072);
         in_valid_4 = 1'b1;
         if (k == 1 || k == 5) q4.push_back(16'(k));
         @(posedge clk);
         #1;
         in_data_4  = 33'(99 * 131072);
         in_valid_4 = 1'b0;
         @(posedge clk);
         #1;
      end
      wait_drain(4, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL decim_drain remaining=%0d expected=0", q4.size());
      end
   endtask

   task automatic test_full_drop;
      bit ok;
      out_ready_1 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         in_data_1  = 33'(k * 131072);
         in_valid_1 = 1'b1;
         if (k <= 4) q1.push_back(16'(k));
         @(posedge clk);
         #1;
      end
      in_valid_1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (fifo_level_1 !== 3'd4 || drop_flag_1 !== 1'b1) begin
         failures++;
         $display("FAIL full_drop level=%0d drop=%b expected=4/1", fifo_level_1, drop_flag_1);
      end
      checks++;
      if (out_valid_1 !== 1'b1 || out_data_1 !== 16'sd1) begin
         failures++;
         $display("FAIL full_head got=%b/%0d expected=1/1", out_valid_1, out_data_1);
      end
      @(posedge clk);
      #1 out_ready_1 = 1'b1;
      wait_drain(1, ok);
      checks++;
      if (!ok || fifo_level_1 !== 3'd0 || drop_flag_1 !== 1'b1) begin
         failures++;
         $display("FAIL drop_drain remaining=%0d level=%0d drop=%b expected=0/0/1", q1.size(), fifo_level_1, drop_flag_1);
      end
      flag_clr_1 = 1'b1;
      @(posedge clk);
      #1 flag_clr_1 = 1'b0;
      checks++;
      if (drop_flag_1 !== 1'b0) begin
         failures++;
         $display("FAIL drop_clear got=%b expected=0", drop_flag_1);
      end
   endtask

   task automatic test_full_push_pop;
      bit ok;
      out_ready_1 = 1'b0;
      for (int k = 11; k <= 23; k++) begin
         in_data_1  = 33'(k * 131072);
         in_valid_1 = 1'b1;
         q1.push_back(16'(k));
         if (k >= 16) out_ready_1 = 1'b1;
         @(negedge clk);
         if (k >= 16) begin
            checks++;
            if (fifo_level_1 !== 3'd4 || drop_flag_1 !== 1'b0) begin
               failures++;
               $display("FAIL full_pushpop_k%0d level=%0d drop=%b expected=4/0", k, fifo_level_1, drop_flag_1);
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid_1 = 1'b0;
      wait_drain(1, ok);
      checks++;
      if (!ok || drop_flag_1 !== 1'b0) begin
         failures++;
         $display("FAIL pushpop_drain remaining=%0d drop=%b expected=0/0", q1.size(), drop_flag_1);
      end
   endtask

   task automatic test_reset_midstream;
      bit ok;
      out_ready_4 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         in_data_4  = 33'(k * 131072);
         in_valid_4 = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid_4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (fifo_level_4 !== 3'd3) begin
         failures++;
         $display("FAIL midrst_pre level=%0d expected=3", fifo_level_4);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid_4 !== 1'b0 || fifo_level_4 !== 3'd0 || out_data_4 !== 16'sd0) begin
         failures++;
         $display("FAIL midrst_async got=%b/%0d/%0d expected=0/0/0", out_valid_4, fifo_level_4, out_data_4);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready_4 = 1'b1;
      in_data_4   = 33'(7 * 131072);
      in_valid_4  = 1'b1;
      q4.push_back(16'sd7);
      @(posedge clk);
      #1 in_valid_4 = 1'b0;
      wait_drain(4, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL midrst_first_kept remaining=%0d expected=0", q4.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_data_1 = '0; in_valid_1 = 1'b0; out_ready_1 = 1'b0; flag_clr_1 = 1'b0;
      in_data_4 = '0; in_valid_4 = 1'b0; out_ready_4 = 1'b0; flag_clr_4 = 1'b0;
      test_reset;
      test_rounding;
      test_saturation;
      test_decimation;
      test_full_drop;
      test_full_push_pop;
      test_reset_midstream;
      checks++;
      if (q1.size() != 0 || q4.size() != 0) begin
         failures++;
         $display("FAIL final_queues q1=%0d q4=%0d expected=0/0", q1.size(), q4.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_out_condition.md
FIR_OUT_CONDITION -- requirements
Module: fir_out_condition

Interface
REQ-001 Parameter IN_WIDTH, default 33: signed width of the FIR accumulator sample accepted on in_data.
REQ-002 Parameter OUT_WIDTH, default 16: signed width of the conditioned output sample.
REQ-003 Parameter SHIFT, default 17: right-shift (divide by 2^SHIFT) applied before narrowing; 1 <= SHIFT < IN_WIDTH.
REQ-004 Parameter DECIM, default 4: decimation ratio, >= 1.
REQ-005 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, >= 2.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 in_data  input  IN_WIDTH  signed FIR output sample.
REQ-009 in_valid  input  1  in_data carries a new sample this cycle; there is no backpressure upstream.
REQ-010 out_data  output  OUT_WIDTH  signed conditioned sample at the FIFO head.
REQ-011 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-012 out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 drop_flag  output  1  sticky: a kept sample was lost because the FIFO was full.
REQ-015 sat_flag  output  1  sticky: a sample was clipped (only with FIR_OUT_SAT_EN defined).
REQ-016 flag_clr  input  1  synchronous clear of drop_flag and sat_flag.

Function
REQ-017 Decimation phase counter (0..DECIM-1) advances by one on each cycle with in_valid=1 and wraps from DECIM-1 to 0; it does not change when in_valid=0.
REQ-018 A sample is kept only when in_valid=1 and the phase equals 0; all other samples are discarded.
REQ-019 Rounding: r = (in_data + 2^(SHIFT-1)) >>> SHIFT, evaluated at IN_WIDTH+1 bits so that the addition cannot overflow; this is round-half-up toward +infinity.
REQ-020 Narrowing of r to OUT_WIDTH follows REQ-031/REQ-032.
REQ-021 The narrowed value is registered in a stage register with a stage_valid bit, one cycle after the kept input.
REQ-022 When stage_valid=1 the stage value is written into the FIFO at the next edge, unless the FIFO is full with no pop in that cycle.
REQ-023 Latency: with the FIFO empty, a sample kept at cycle N produces out_valid=1 and the correct out_data at cycle N+2.
REQ-024 FIFO is first-word-fall-through: out_data always equals the head entry.
REQ-025 Simultaneous push and pop: allowed at any level, including full; fifo_level is unchanged and ordering is preserved.
REQ-026 Push while full with no pop: the sample is dropped, FIFO contents and level are unchanged, and drop_flag is set.
REQ-027 Pop while empty: not possible, because out_valid=0.
REQ-028 Write and read pointers wrap modulo FIFO_DEPTH; the level saturates at FIFO_DEPTH and never exceeds it.
REQ-029 flag_clr takes priority over a set event occurring in the same cycle.

Reset
REQ-030 While rst_n=0: phase=0, stage_valid=0, FIFO pointers=0, fifo_level=0, out_valid=0, out_data=0, drop_flag=0, sat_flag=0. Reset mid-operation discards all buffered samples, and the first in_valid after release is kept.

Configuration
REQ-031 With FIR_OUT_SAT_EN defined, r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sat_flag is set on any clamp.
REQ-032 Without FIR_OUT_SAT_EN, the low OUT_WIDTH bits of r are taken (two's-complement wrap) and sat_flag is tied to 0.

Verification
REQ-033 Rounding, DECIM=1: in_data=65536 -> 1; 65535 -> 0; -65536 -> 0; -65537 -> -1; 131072*5 -> 5; each appears at in_valid cycle + 2.
REQ-034 Saturation: in_data=2^32-1 -> 32767 with sat_flag=1 when FIR_OUT_SAT_EN is defined; -32768 with sat_flag=0 when it is undefined. in_data=-2^32 -> -32768 in both builds.
REQ-035 Decimation, DECIM=4: in_valid continuous with samples k*131072 for k=1..8 -> outputs exactly 1 and 5. in_valid gapped every other cycle -> same outputs.
REQ-036 Full/drop: out_ready=0, DECIM=1, six consecutive samples -> fifo_level=4, drop_flag=1; draining yields only the first four values in order. A flag_clr pulse clears drop_flag.
REQ-037 Full with simultaneous push and pop: FIFO full, out_ready=1, continuous input -> level stays 4, drop_flag stays 0, no sample lost.
REQ-038 Reset mid-stream: rst_n low for 1 cycle with 3 entries buffered and phase=2 -> out_valid=0 and fifo_level=0 immediately; the next in_valid sample is kept.
